// File: rtl/fetch_queue_if.sv
// Fetch-queue bus bundle: instruction-memory handshake, execute redirect and decode-side head.
// The master modport is the fetch queue; the slave modport is the memory/pipeline side.
interface fetch_queue_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  ImemReq;
  logic [DATA_WIDTH-1:0] ImemAddr;
  logic                  ImemGnt;
  logic                  ImemRValid;
  logic [DATA_WIDTH-1:0] ImemRData;
  logic                  Redirect;
  logic [DATA_WIDTH-1:0] RedirectPC;
  logic                  StallD;
  logic                  ValidF;
  logic [DATA_WIDTH-1:0] InstrF;
  logic [DATA_WIDTH-1:0] PCF;
  logic [DATA_WIDTH-1:0] PCPlus4F;

  modport master (
    output ImemReq, ImemAddr, ValidF, InstrF, PCF, PCPlus4F,
    input  ImemGnt, ImemRValid, ImemRData, Redirect, RedirectPC, StallD
  );

  modport slave (
    input  ImemReq, ImemAddr, ValidF, InstrF, PCF, PCPlus4F,
    output ImemGnt, ImemRValid, ImemRData, Redirect, RedirectPC, StallD
  );
endinterface

// File: rtl/fetch_queue.sv
// RV32I fetch front-end: credit-limited request issue, in-order response FIFO, redirect flush.
// Define FETCH_BYPASS_EN to let a response into an empty queue reach decode in the same cycle.
module fetch_queue #(
  parameter int unsigned          DATA_WIDTH = 32,
  parameter int unsigned          DEPTH      = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_PC  = '0
) (
  input logic           clk,
  input logic           rst_n,
  fetch_queue_if.master bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [DATA_WIDTH-1:0] Nop    = DATA_WIDTH'(32'h0000_0013);
  localparam logic [DATA_WIDTH-1:0] Four   = DATA_WIDTH'(4);
  localparam logic [CntW:0]         DepthC = (CntW + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] fpcQ, fpcD, rpcQ, rpcD;
  logic [CntW-1:0]       occQ, occD, outsQ, outsD, dropQ, dropD;
  logic [PtrW-1:0]       rdPtrQ, rdPtrD, wrPtrQ, wrPtrD;
  logic [DATA_WIDTH-1:0] instrMem [DEPTH];
  logic [DATA_WIDTH-1:0] pcMem    [DEPTH];

  logic                  credit, imemReq, accept, rspKeep, bypass, push, pop, headValid;
  logic [DATA_WIDTH-1:0] headPc;

  // Queued plus in-flight never exceeds DEPTH, so a response always finds a free slot.
  assign credit    = ({1'b0, occQ} + {1'b0, outsQ}) < DepthC;
  assign imemReq   = rst_n && !bus.Redirect && credit;
  assign accept    = imemReq && bus.ImemGnt;
  assign rspKeep   = bus.ImemRValid && (dropQ == '0) && !bus.Redirect;
  assign headValid = (occQ != '0);

`ifdef FETCH_BYPASS_EN
  assign bypass = rspKeep && !headValid;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed word consumed by decode never enters the FIFO.
  assign push = rspKeep && !(bypass && !bus.StallD);
  assign pop  = headValid && !bus.StallD && !bus.Redirect;

  always_comb begin
    fpcD   = fpcQ;
    rpcD   = rpcQ;
    occD   = occQ;
    dropD  = dropQ;
    rdPtrD = rdPtrQ;
    wrPtrD = wrPtrQ;
    outsD  = outsQ + CntW'(accept) - CntW'(bus.ImemRValid);
    if (bus.Redirect) begin
      fpcD   = bus.RedirectPC;
      rpcD   = bus.RedirectPC;
      occD   = '0;
      rdPtrD = '0;
      wrPtrD = '0;
      // Every request still in flight after this edge belongs to the old path.
      dropD  = outsD;
    end else begin
      if (accept) begin
        fpcD = fpcQ + Four;
      end
      if (bus.ImemRValid && (dropQ != '0)) begin
        dropD = dropQ - CntW'(1);
      end
      if (rspKeep) begin
        rpcD = rpcQ + Four;
      end
      if (push) begin
        wrPtrD = wrPtrQ + PtrW'(1);
      end
      if (pop) begin
        rdPtrD = rdPtrQ + PtrW'(1);
      end
      occD = occQ + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpcQ   <= RESET_PC;
      rpcQ   <= RESET_PC;
      occQ   <= '0;
      outsQ  <= '0;
      dropQ  <= '0;
      rdPtrQ <= '0;
      wrPtrQ <= '0;
    end else begin
      fpcQ   <= fpcD;
      rpcQ   <= rpcD;
      occQ   <= occD;
      outsQ  <= outsD;
      dropQ  <= dropD;
      rdPtrQ <= rdPtrD;
      wrPtrQ <= wrPtrD;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instrMem[wrPtrQ] <= bus.ImemRData;
      pcMem[wrPtrQ]    <= rpcQ;
    end
  end

  always_comb begin
    bus.ImemReq  = imemReq;
    bus.ImemAddr = {fpcQ[DATA_WIDTH-1:2], 2'b00};
    bus.ValidF   = headValid || bypass;
    bus.InstrF   = Nop;
    headPc       = rpcQ;
    if (headValid) begin
      bus.InstrF = instrMem[rdPtrQ];
      headPc     = pcMem[rdPtrQ];
    end else if (bypass) begin
      bus.InstrF = bus.ImemRData;
    end
    bus.PCF      = headPc;
    bus.PCPlus4F = headPc + Four;
  end

  assert property (@(posedge clk) disable iff (!rst_n) !(push && (occQ == CntW'(DEPTH))));

endmodule
